// File: rtl/trace_step_loader_if.sv
// Handshake bundle between a trace word producer / step consumer and the loader.
// Both streams are valid/ready: a beat transfers on a rising edge where valid and ready are both 1.
interface trace_step_loader_if #(
  parameter int STEP_W = 560
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_data;
  logic              in_last;
  logic              step_valid;
  logic              step_ready;
  logic [STEP_W-1:0] step;
  logic [31:0]       step_idx;

  modport master (
    output in_valid, in_data, in_last, step_ready,
    input  in_ready, step_valid, step, step_idx
  );

  modport slave (
    input  in_valid, in_data, in_last, step_ready,
    output in_ready, step_valid, step, step_idx
  );
endinterface

// File: rtl/trace_step_loader.sv
// Packs a stream of 32-bit trace words into WORDS-word steps held in one buffer,
// presents each step over valid/ready, and flags nonzero padding or truncated traces.
module trace_step_loader #(
  parameter int STEP_W = 560,
  parameter int WORDS  = 18
) (
  input  logic                clk,
  input  logic                rst_n,
  trace_step_loader_if.slave  bus,
  output logic                trace_done,
  output logic                err_pad,
  output logic                err_short,
  output logic [1:0]          dbg_state
);
  localparam int LAST   = WORDS - 1;
  localparam int TAIL_W = STEP_W - 32 * LAST;
  localparam int CW     = $clog2(WORDS);

  typedef enum logic [1:0] {FILL = 2'd0, FULL = 2'd1, DONE = 2'd2, ERR = 2'd3} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     wcnt_q;
  logic [STEP_W-1:0] step_q;
  logic [31:0]       step_idx_q;
  logic              last_q;
  logic              err_pad_q, err_short_q;

  logic accept, handshake, at_last, pad_bad;

  assign accept    = bus.in_valid && (state_q == FILL);
  assign handshake = bus.step_ready && (state_q == FULL);
  assign at_last   = (wcnt_q == CW'(LAST));
  assign pad_bad   = (bus.in_data[31:TAIL_W] != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FILL;
    else        state_q <= state_d;
  end

  // A padding error on the final word takes priority over presenting the step.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: begin
        if (accept) begin
          if (at_last)          state_d = pad_bad ? ERR : FULL;
          else if (bus.in_last) state_d = ERR;
        end
      end
      FULL:    if (bus.step_ready) state_d = last_q ? DONE : FILL;
      DONE:    state_d = DONE;
      default: state_d = ERR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q      <= '0;
      step_q      <= '0;
      step_idx_q  <= '0;
      last_q      <= 1'b0;
      err_pad_q   <= 1'b0;
      err_short_q <= 1'b0;
    end else begin
      if (accept) begin
        if (at_last) begin
          step_q[STEP_W-1 -: TAIL_W] <= bus.in_data[TAIL_W-1:0];
          last_q <= bus.in_last;
          if (pad_bad) err_pad_q <= 1'b1;
        end else begin
          for (int k = 0; k < LAST; k++) begin
            if (wcnt_q == CW'(k)) step_q[32*k +: 32] <= bus.in_data;
          end
          wcnt_q <= wcnt_q + CW'(1);
          if (bus.in_last) err_short_q <= 1'b1;
        end
      end
      // wcnt parks at LAST while the step is presented and rewinds on consumption.
      if (handshake) begin
        wcnt_q     <= '0;
        step_idx_q <= step_idx_q + 32'd1;
      end
    end
  end

  assign bus.in_ready   = (state_q == FILL);
  assign bus.step_valid = (state_q == FULL);
  assign bus.step       = step_q;
  assign bus.step_idx   = step_idx_q;
  assign trace_done     = (state_q == DONE);
  assign err_pad        = err_pad_q;
  assign err_short      = err_short_q;
  assign dbg_state      = state_q;
endmodule

// File: tb/tb_trace_step_loader.sv
// Directed bench for trace_step_loader: table of whole-trace cases plus
// back-pressure, asynchronous reset mid-fill and bubbly multi-step sequences.
module tb_trace_step_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  trace_step_loader_if bus ();
  logic       trace_done, err_pad, err_short;
  logic [1:0] dbg_state;

  trace_step_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .trace_done (trace_done),
    .err_pad    (err_pad),
    .err_short  (err_short),
    .dbg_state  (dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] words [18];

  typedef struct {
    logic [31:0] w17;
    logic        last17;
    int          short_at;
    logic        exp_valid;
    logic        exp_pad;
    logic        exp_short;
    logic        exp_done;
  } vec_t;

  task automatic chk(input string name, input logic [559:0] act, input logic [559:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [559:0] golden();
    logic [559:0] g;
    g = '0;
    for (int k = 0; k < 17; k++) g[32*k +: 32] = words[k];
    g[559:544] = words[17][15:0];
    return g;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    bus.step_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Offers one word (after random idle cycles when duty<100) and returns at the negedge after its accept.
  task automatic send_word(input logic [31:0] d, input logic l, input int duty);
    int guard;
    guard = 0;
    while (duty < 100 && $urandom_range(0, 99) >= duty) begin
      bus.in_valid = 1'b0;
      bus.in_data = $urandom;
      bus.in_last = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data = d;
    bus.in_last = l;
    while (!bus.in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk("in_ready_timeout", 1'b0, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
  endtask

  task automatic take_step(input int stall, input logic [31:0] exp_idx, input logic [559:0] exp);
    int guard;
    guard = 0;
    while (!bus.step_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("step_valid_rise", bus.step_valid, 1'b1);
    for (int i = 0; i < stall; i++) begin
      chk("stall_valid", bus.step_valid, 1'b1);
      chk("stall_in_ready", bus.in_ready, 1'b0);
      chk("stall_step", bus.step, exp);
      chk("stall_idx", bus.step_idx, exp_idx);
      @(negedge clk);
    end
    chk("step", bus.step, exp);
    chk("step_idx", bus.step_idx, exp_idx);
    bus.step_ready = 1'b1;
    @(negedge clk);
    bus.step_ready = 1'b0;
    chk("valid_after_hs", bus.step_valid, 1'b0);
  endtask

  vec_t vecs [5];

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    bus.step_ready = 1'b0;

    vecs[0] = '{32'h0000_0011, 1'b1, -1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{32'h0001_0005, 1'b0, -1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{32'h0000_0011, 1'b0,  5, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'hFFFF_0011, 1'b1, -1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{32'h0000_ABCD, 1'b0, -1, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset state while rst_n is still low.
    @(negedge clk);
    chk("rst_step_valid", bus.step_valid, 1'b0);
    chk("rst_step", bus.step, '0);
    chk("rst_step_idx", bus.step_idx, '0);
    chk("rst_trace_done", trace_done, 1'b0);
    chk("rst_err_pad", err_pad, 1'b0);
    chk("rst_err_short", err_short, 1'b0);
    do_reset();
    chk("rst_in_ready", bus.in_ready, 1'b1);

    for (int v = 0; v < 5; v++) begin
      logic saw;
      do_reset();
      for (int k = 0; k < 17; k++) words[k] = 32'(k);
      words[17] = vecs[v].w17;
      for (int k = 0; k < 18; k++) begin
        if (vecs[v].short_at >= 0 && k > vecs[v].short_at) break;
        send_word(words[k], (k == 17) ? vecs[v].last17 : (k == vecs[v].short_at), 100);
      end
      chk("tbl_err_pad", err_pad, vecs[v].exp_pad);
      chk("tbl_err_short", err_short, vecs[v].exp_short);
      chk("tbl_state", dbg_state, vecs[v].exp_valid ? 2'd1 : 2'd3);
      if (vecs[v].exp_valid) begin
        take_step(0, 32'd0, golden());
        chk("tbl_trace_done", trace_done, vecs[v].exp_done);
        chk("tbl_in_ready_after", bus.in_ready, !vecs[v].exp_done);
      end else begin
        saw = 1'b0;
        for (int i = 0; i < 20; i++) begin
          if (bus.step_valid) saw = 1'b1;
          @(negedge clk);
        end
        chk("tbl_never_valid", saw, 1'b0);
        chk("tbl_err_in_ready", bus.in_ready, 1'b0);
        chk("tbl_err_done", trace_done, 1'b0);
        chk("tbl_err_pad_held", err_pad, vecs[v].exp_pad);
        chk("tbl_err_short_held", err_short, vecs[v].exp_short);
      end
    end

    // Back-pressure: three steps, each held 10 cycles before consumption.
    do_reset();
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 18; k++) words[k] = 32'h0100_0000 * 32'(s + 1) + 32'(k);
      words[17] = {16'h0000, words[17][15:0]};
      for (int k = 0; k < 18; k++) send_word(words[k], (s == 2) && (k == 17), 100);
      take_step(10, 32'(s), golden());
    end
    chk("bp_trace_done", trace_done, 1'b1);
    chk("bp_in_ready", bus.in_ready, 1'b0);

    // Asynchronous reset after 9 words, then a fresh full step.
    do_reset();
    for (int k = 0; k < 9; k++) send_word(32'hDEAD_0000 + 32'(k), 1'b0, 100);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_step", bus.step, '0);
    chk("arst_step_valid", bus.step_valid, 1'b0);
    chk("arst_step_idx", bus.step_idx, '0);
    chk("arst_errs", {err_pad, err_short, trace_done}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 18; k++) words[k] = 32'h0000_0100 + 32'(k);
    for (int k = 0; k < 18; k++) send_word(words[k], 1'b0, 100);
    take_step(0, 32'd0, golden());
    chk("arst_refill_ready", bus.in_ready, 1'b1);

    // Bubbly input at ~30% duty over 4 steps; the last step checks step_idx wrap.
    do_reset();
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 18; k++) words[k] = $urandom;
      words[17] = {16'h0000, words[17][15:0]};
      for (int k = 0; k < 18; k++) send_word(words[k], (s == 3) && (k == 17), 30);
      if (s < 3) begin
        take_step(0, 32'(s), golden());
      end else begin
        force dut.step_idx_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.step_idx_q;
        @(negedge clk);
        take_step(0, 32'hFFFF_FFFF, golden());
        chk("wrap_step_idx", bus.step_idx, 32'd0);
      end
    end
    chk("bub_trace_done", trace_done, 1'b1);
    chk("bub_errs", {err_pad, err_short}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/trace_step_loader.md
# trace_step_loader

Upstream feeder for the tiny86 step datapath. Accepts a trace as a stream of 32-bit words and packs every 18 words into one 560-bit trace step (instruction, register file, two memory hints). Holds each step in a single buffer and presents it to the step consumer through a valid/ready handshake. Flags malformed traces: nonzero padding or truncation.

## Interface

Parameters:
- STEP_W, 560, width of one trace step
- WORDS, 18, input words per step, equal to ceil(STEP_W/32)

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input word offered
- in_ready  out  1  loader can accept a word
- in_data  in  32  trace word
- in_last  in  1  marks the final word of the whole trace
- step_valid  out  1  step buffer holds a complete step
- step_ready  in  1  consumer takes the step
- step  out  560  packed step; stable while step_valid=1
- step_idx  out  32  index of the step currently presented; counts consumed steps
- trace_done  out  1  sticky; last step of the trace has been consumed
- err_pad  out  1  sticky; nonzero bits in in_data[31:16] of word 17
- err_short  out  1  sticky; in_last arrived on a word other than word 17

## Operation

- States: FILL, FULL, DONE, ERR. Word counter wcnt is 0..17.
- Word accept: in_valid & in_ready.
- Packing: word k is written to step[32k+31:32k] for k=0..16. Word 17 writes in_data[15:0] to step[559:544].
- FILL:
  - in_ready=1 and step_valid=0.
  - On accept with wcnt<17: store the word, wcnt+1. If in_last=1, go to ERR and set err_short.
  - On accept with wcnt=17: store the word and go to FULL. If in_data[31:16]≠0, go to ERR and set err_pad instead. ERR wins over FULL.
  - On the word-17 accept, record in_last into last_q.
- FULL:
  - in_ready=0 and step_valid=1.
  - On step_valid & step_ready: wcnt←0 and step_idx←step_idx+1, wrapping modulo 2^32.
  - Next state is DONE if last_q=1, otherwise FILL.
- DONE: in_ready=0, step_valid=0, trace_done=1. Stays in DONE until reset; input words are ignored.
- ERR: in_ready=0 and step_valid=0. err flags stay held until reset. A partial step is never presented.
- step contents persist after consumption until overwritten by new words; consumers must qualify with step_valid.
- in_last on word 17 with bad padding: err_pad=1, err_short=0, trace_done never asserts.
- Reset at any point, including mid-fill or mid-handshake, aborts everything. The current partial step is discarded.

## Timing

- Reset values:
  - state=FILL, wcnt=0, step=0, step_idx=0, last_q=0.
  - step_valid=0, trace_done=0, err_pad=0, err_short=0.
  - in_ready=1 once rst_n is high.
- All outputs are registered or decoded from state; there are no combinational paths from inputs to outputs.
- Latency: step_valid rises on the edge that accepts word 17, so it is visible the next cycle.
- Minimum step period is 19 cycles: 18 accepts plus 1 handshake cycle. in_ready is 0 during the handshake cycle.
- step_valid, once high, stays high with step and step_idx unchanged until step_ready is sampled high.
- in_ready returns to 1 the cycle after a handshake when the next state is FILL.
- in_valid may toggle arbitrarily. Gaps in valid stall wcnt without losing data.

## Test plan

- Single clean step: 18 words 0x00000000..0x00000011 with in_last on word 17 and step_ready=1.
  - step_valid for exactly 1 cycle.
  - step[31:0]=0, step[543:512]=0x10, step[559:544]=0x0011, step_idx=0.
  - trace_done=1 the cycle after the handshake.
- Back-pressure over three steps: hold step_ready=0 for 10 cycles on each step.
  - step is stable and in_ready=0 throughout the stall.
  - step_idx reads 0, 1, 2 on the three presentations.
  - Total 18 accepts per step, with no word dropped or duplicated.
- Bad padding: word 17 = 0x00010005.
  - err_pad=1 the next cycle, step_valid never rises, in_ready=0 thereafter.
- Truncated trace: in_last on word 5.
  - err_short=1, err_pad=0, step_valid never rises.
- Reset mid-fill: assert rst_n=0 asynchronously after 9 words, release, then send a full 18-word step.
  - All outputs are at reset values during reset.
  - The delivered step contains only the post-reset words, with step_idx=0.
- Bubbly input: in_valid randomly at 30% duty over 4 steps, in_last on the final word.
  - All 4 steps are bit-exact against the golden packing.
  - trace_done=1 after the 4th handshake; the counter wrap is checked by force-loading step_idx=0xFFFFFFFF, which reads 0 after the next handshake.
